pipe_adder: RTL and testbench



---
 rtl/pipe_adder.sv | 140 ++++++++++++++
 tb/tb_pipe_adder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined ripple-carry adder with carry-in/carry-out and a
// valid/ready handshake on both sides. A WIDTH-bit add is split into
// NSEG = WIDTH/SEG_W segments. Each stage adds one segment and registers the
// carry for the next stage.
// Optional feature: define ADD_OVF_EN to add the signed-overflow output ovf.
module pipe_adder #(
   parameter int WIDTH = 8,
   parameter int SEG_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             cout
`ifdef ADD_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NSEG = WIDTH / SEG_W;

   generate
      if (WIDTH < 1 || (WIDTH % SEG_W) != 0) begin : g_bad_param
         $error("pipe_adder: WIDTH must be a positive multiple of SEG_W");
      end
   endgenerate

   // Per-stage state. acc_reg[k] holds {A[WIDTH-1:HI], sum[HI-1:0]}, so
   // the not-yet-added upper bits of A share one word with the partial sum.
   // brem_reg[k] holds the not-yet-added upper bits of B, right-aligned.
   logic [NSEG-1:0]  valid_reg;
   logic [NSEG-1:0]  carry_reg;
   logic [WIDTH-1:0] acc_reg  [NSEG];
   logic [WIDTH-1:0] brem_reg [NSEG];

   // Stage inputs: taken from the ports for stage 0, otherwise from the
   // previous stage's registers.
   logic [NSEG-1:0]  feed_valid;
   logic [NSEG-1:0]  feed_carry;
   logic [WIDTH-1:0] feed_acc  [NSEG];
   logic [WIDTH-1:0] feed_b    [NSEG];
   logic [WIDTH-1:0] acc_next  [NSEG];
   logic [WIDTH-1:0] brem_next [NSEG];
   logic [SEG_W:0]   seg_sum   [NSEG];

   logic [NSEG-1:0]  ready;

   // Backpressure chain: a stage may load if it is empty or its successor moves.
   always_comb begin
      logic chain;
      chain = out_ready;
      ready = '0;
      for (int k = NSEG - 1; k >= 0; k--) begin
         chain    = !valid_reg[k] | chain;
         ready[k] = chain;
      end
   end

   assign in_ready  = ready[0];
   assign out_valid = valid_reg[NSEG-1];
   assign S         = acc_reg[NSEG-1];
   assign cout      = carry_reg[NSEG-1];

   genvar gi;
   generate
      for (gi = 0; gi < NSEG; gi++) begin : g_stage
         localparam int LO = SEG_W * gi;
         localparam int HI = LO + SEG_W;
         localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG_W{1'b1}}) << LO;

         if (gi == 0) begin : g_head
            assign feed_valid[gi] = in_valid;
            assign feed_carry[gi] = cin;
            assign feed_acc[gi]   = A;
            assign feed_b[gi]     = B;
         end else begin : g_body
            assign feed_valid[gi] = valid_reg[gi-1];
            assign feed_carry[gi] = carry_reg[gi-1];
            assign feed_acc[gi]   = acc_reg[gi-1];
            assign feed_b[gi]     = brem_reg[gi-1];
         end

         // Segment add: A bits still sit in place at [HI-1:LO], while the
         // B segment is always at the bottom of the right-aligned remainder.
         assign seg_sum[gi]   = {1'b0, feed_acc[gi][HI-1:LO]}
                              + {1'b0, feed_b[gi][SEG_W-1:0]}
                              + {{SEG_W{1'b0}}, feed_carry[gi]};
         assign acc_next[gi]  = (feed_acc[gi] & ~SEG_MASK)
                              | (WIDTH'(seg_sum[gi][SEG_W-1:0]) << LO);
         assign brem_next[gi] = feed_b[gi] >> SEG_W;

         // Stage register: advance when ready, hold otherwise; data only
         // changes on a valid load so bubbles leave the last values intact.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               valid_reg[gi] <= 1'b0;
               carry_reg[gi] <= 1'b0;
               acc_reg[gi]   <= '0;
               brem_reg[gi]  <= '0;
            end else if (ready[gi]) begin
               valid_reg[gi] <= feed_valid[gi];
               if (feed_valid[gi]) begin
                  carry_reg[gi] <= seg_sum[gi][SEG_W];
                  acc_reg[gi]   <= acc_next[gi];
                  brem_reg[gi]  <= brem_next[gi];
               end
            end
         end
      end
   endgenerate

`ifdef ADD_OVF_EN
   logic ovf_reg;
   logic ovf_next;

   // The operand sign bits are still unadded when they reach the top
   // segment, so overflow comes straight from the last stage's inputs.
   assign ovf_next = (feed_acc[NSEG-1][WIDTH-1] == feed_b[NSEG-1][SEG_W-1])
                   & (seg_sum[NSEG-1][SEG_W-1] != feed_acc[NSEG-1][WIDTH-1]);

   // Overflow register loads in step with the last stage's sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_reg <= 1'b0;
      end else if (ready[NSEG-1] && feed_valid[NSEG-1]) begin
         ovf_reg <= ovf_next;
      end
   end

   assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Testbench for pipe_adder (WIDTH=8, SEG_W=2, so 4 stages). Works with or
// without ADD_OVF_EN.
module tb_pipe_adder;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b1;
   logic       in_valid  = 1'b0;
   logic       in_ready;
   logic [7:0] A         = 8'h00;
   logic [7:0] B         = 8'h00;
   logic       cin       = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] S;
   logic       cout;
`ifdef ADD_OVF_EN
   logic       ovf;
`endif

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       ci;
      logic [7:0] s;
      logic       co;
      logic       ov;
   } vec_t;

   int   n_checks = 0;
   int   n_errors = 0;
   vec_t exp_q[$];
   logic last_acc;
   int   fire_cnt;
   int   first_fire;
   int   last_fire;
   int   cyc;

   vec_t stream_tab[16];
   vec_t tab[10];
   vec_t bp[5];
   vec_t idle;

   pipe_adder #(.WIDTH(8), .SEG_W(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .S         (S),
      .cout      (cout)
`ifdef ADD_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic ci,
                               input logic [7:0] s, input logic co, input logic ov);
      vec_t v;
      v.a = a; v.b = b; v.ci = ci; v.s = s; v.co = co; v.ov = ov;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
      end
   endtask

   // One clock cycle: called at posedge+1, drives inputs, samples the
   // handshake on both sides, scores any result leaving the pipe, then
   // returns at the next posedge+1.
   task automatic drive_cycle(input logic v_in, input vec_t v, input logic rdy);
      vec_t e;
      in_valid  = v_in;
      A         = v.a;
      B         = v.b;
      cin       = v.ci;
      out_ready = rdy;
      #1;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("spurious out_valid", 32'(out_valid), 32'd0);
         end else begin
            e = exp_q.pop_front();
            $display("result: %h + %h + %b -> S=%h cout=%b (want %h/%b)",
                     e.a, e.b, e.ci, S, cout, e.s, e.co);
            check($sformatf("S for %h+%h+%b", e.a, e.b, e.ci), 32'(S), 32'(e.s));
            check($sformatf("cout for %h+%h+%b", e.a, e.b, e.ci), 32'(cout), 32'(e.co));
`ifdef ADD_OVF_EN
            check($sformatf("ovf for %h+%h+%b", e.a, e.b, e.ci), 32'(ovf), 32'(e.ov));
`endif
            fire_cnt++;
            if (first_fire < 0) first_fire = cyc;
            last_fire = cyc;
         end
      end
      last_acc = v_in && in_ready;
      if (last_acc) exp_q.push_back(v);
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      for (int k = 0; k < 30 && exp_q.size() > 0; k++) drive_cycle(1'b0, idle, 1'b1);
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic latency_test(input string name, input vec_t v);
      int n;
      drive_cycle(1'b1, v, 1'b1);
      check({name, " accept"}, 32'(last_acc), 32'd1);
      n = 1;
      while (!out_valid && n < 20) begin
         drive_cycle(1'b0, idle, 1'b1);
         n++;
      end
      check({name, " latency"}, 32'(n), 32'd4);
      drain({name, " drain"});
   endtask

   initial begin
      int i;
      int g;

      idle = mk(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int k = 0; k < 16; k++)
         stream_tab[k] = mk(8'(k), 8'(2 * k), k[0], 8'(3 * k + (k % 2)), 1'b0, 1'b0);
      tab[0] = mk(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      tab[1] = mk(8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0);
      tab[2] = mk(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
      tab[3] = mk(8'h7F, 8'h80, 1'b0, 8'hFF, 1'b0, 1'b0);
      tab[4] = mk(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      tab[5] = mk(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
      tab[6] = mk(8'h3C, 8'h4D, 1'b0, 8'h89, 1'b0, 1'b1);
      tab[7] = mk(8'hC8, 8'h9C, 1'b0, 8'h64, 1'b1, 1'b1);
      tab[8] = mk(8'h0F, 8'h01, 1'b1, 8'h11, 1'b0, 1'b0);
      tab[9] = mk(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0);
      bp[0]  = mk(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
      bp[1]  = mk(8'h30, 8'h40, 1'b0, 8'h70, 1'b0, 1'b0);
      bp[2]  = mk(8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0);
      bp[3]  = mk(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
      bp[4]  = mk(8'h02, 8'h02, 1'b0, 8'h04, 1'b0, 1'b0);
      fire_cnt = 0; first_fire = -1; last_fire = -1; cyc = 0; last_acc = 1'b0;

      // Reset state
      #2 rst_n = 1'b0;
      #1;
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset S", 32'(S), 32'd0);
      check("reset cout", 32'(cout), 32'd0);
`ifdef ADD_OVF_EN
      check("reset ovf", 32'(ovf), 32'd0);
`endif
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("in_ready after reset", 32'(in_ready), 32'd1);

      // First transaction latency: FF + 01
      latency_test("first", tab[0]);

      // Back-to-back stream, one result per cycle in order
      fire_cnt = 0; first_fire = -1; last_fire = -1;
      for (int k = 0; k < 16; k++) begin
         drive_cycle(1'b1, stream_tab[k], 1'b1);
         check($sformatf("stream accept %0d", k), 32'(last_acc), 32'd1);
      end
      drain("stream drain");
      check("stream count", 32'(fire_cnt), 32'd16);
      check("stream contiguous", 32'(last_fire - first_fire + 1), 32'd16);

      // Corner-case table with intermittent out_ready
      i = 0; g = 0;
      while (i < 10 && g < 200) begin
         drive_cycle(1'b1, tab[i], (g % 3) != 2);
         if (last_acc) i++;
         g++;
      end
      check("table accepted", 32'(i), 32'd10);
      drain("table drain");

      // Backpressure: four accepts fill the pipe, fifth waits for out_ready
      for (int k = 0; k < 4; k++) begin
         drive_cycle(1'b1, bp[k], 1'b0);
         check($sformatf("bp accept %0d", k), 32'(last_acc), 32'd1);
      end
      for (int h = 0; h < 5; h++) begin
         drive_cycle(1'b1, bp[4], 1'b0);
         check($sformatf("bp full in_ready %0d", h), 32'(last_acc), 32'd0);
         check($sformatf("bp hold out_valid %0d", h), 32'(out_valid), 32'd1);
         check($sformatf("bp hold S %0d", h), 32'(S), 32'h30);
      end
      drive_cycle(1'b1, bp[4], 1'b1);
      check("bp pass-through accept", 32'(last_acc), 32'd1);
      drain("bp drain");

      // Bubble collapse: one item stalls at the end, three more fill behind it
      drive_cycle(1'b1, tab[9], 1'b0);
      check("bubble accept 0", 32'(last_acc), 32'd1);
      for (int k = 0; k < 6; k++) drive_cycle(1'b0, idle, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         drive_cycle(1'b1, tab[k], 1'b0);
         check($sformatf("bubble accept %0d", k), 32'(last_acc), 32'd1);
      end
      drive_cycle(1'b1, tab[4], 1'b0);
      check("bubble full", 32'(last_acc), 32'd0);
      drain("bubble drain");

      // Reset with items in flight
      drive_cycle(1'b1, tab[7], 1'b0);
      drive_cycle(1'b1, tab[6], 1'b0);
      drive_cycle(1'b1, tab[8], 1'b0);
      drive_cycle(1'b0, idle, 1'b0);
      drive_cycle(1'b0, idle, 1'b0);
      check("pre-reset out_valid", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid reset out_valid", 32'(out_valid), 32'd0);
      check("mid reset S", 32'(S), 32'd0);
      check("mid reset cout", 32'(cout), 32'd0);
`ifdef ADD_OVF_EN
      check("mid reset ovf", 32'(ovf), 32'd0);
`endif
      exp_q.delete();
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 6; k++) drive_cycle(1'b0, idle, 1'b1);
      latency_test("post-reset", tab[4]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog timeout");
   end

endmodule
